am_lock_bip_module: RTL and testbench

- Per-lane alignment-marker (AM) lock block for the 100GbE PCS receive path.
- Sits after block lock and before lane reorder/deskew.
- Against a parametrised AM table, it:
  - finds and confirms AMs at a programmable period;
  - tolerates a programmable number of bad AMs;
  - reports the lane ID;
  - replaces matched AMs with an idle control block;
  - checks BIP3 and keeps a saturating BIP error counter.

---
 rtl/am_lock_bip_module.sv | 224 ++++++++++++++++++++++
 tb/tb_am_lock_bip_module.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/am_lock_bip_module.sv
// Per-lane alignment-marker lock for the 100GbE PCS receive path. It finds and tracks
// AMs, swaps accepted AMs for an idle block, and checks BIP3 between consecutive markers.
module am_lock_bip_module #(
    parameter int LEN_CODED_BLOCK = 66,
    parameter int N_ALIGNER = 20,
    parameter int NB_LANE_ID = $clog2(N_ALIGNER),
    parameter logic [N_ALIGNER*24-1:0] AM_TABLE = {
        24'hC0F0E5, 24'h5F662A, 24'hADD6B7, 24'hC4314C, 24'h3536CD,
        24'h83C7CA, 24'h1AF8BD, 24'h5CB9B2, 24'hB99155, 24'hFD6C99,
        24'h68C9FB, 24'hA02476, 24'h7B4566, 24'h9A4A26, 24'hDD14C2,
        24'hF50709, 24'h4D957B, 24'h594BE8, 24'h9D718E, 24'hC16821},
    parameter int NB_PERIOD = 15,
    parameter int NB_INV_AM = 3,
    parameter int NB_ERROR_COUNTER = 32
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_valid,
    input  logic                        i_block_lock,
    input  logic [LEN_CODED_BLOCK-1:0]  i_data,
    input  logic [NB_PERIOD-1:0]        i_am_period,
    input  logic [NB_INV_AM-1:0]        i_max_invalid_am,
    input  logic                        i_clear_counter,
    output logic [LEN_CODED_BLOCK-1:0]  o_data,
    output logic                        o_valid,
    output logic [NB_LANE_ID-1:0]       o_lane_id,
    output logic                        o_am_lock,
    output logic                        o_resync,
    output logic                        o_start_of_lane,
    output logic                        o_bip_error,
    output logic [NB_ERROR_COUNTER-1:0] o_bip_error_count
);

    localparam logic [LEN_CODED_BLOCK-1:0] IDLE_BLOCK = {2'b10, 8'h1E, 56'h0};
    localparam logic [NB_INV_AM:0]         INV_ONE    = 1;

    typedef enum logic [1:0] {LOCK_INIT, FIND_1ST, COUNT_1, COUNT_NEXT} state_t;

    state_t                      state_q, state_d;
    logic [NB_PERIOD-1:0]        timer_q, timer_d;
    logic [NB_LANE_ID-1:0]       lane_q, lane_d;
    logic [NB_INV_AM-1:0]        inv_q, inv_d;
    logic [7:0]                  acc_q, acc_d;
    logic [LEN_CODED_BLOCK-1:0]  data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        lock_q, lock_d;
    logic                        resync_q, resync_d;
    logic                        sol_q, sol_d;
    logic                        bip_err_q, bip_err_d;
    logic [NB_ERROR_COUNTER-1:0] cnt_q, cnt_d;

    logic                  accept, expected, any_hit, lane_hit, am_accept, bip_inc;
    logic [NB_LANE_ID-1:0] hit_idx;
    logic [23:0]           lane_entry;
    logic [7:0]            blk_bip;
    logic [NB_INV_AM:0]    inv_next, inv_limit;

    function automatic logic am_match(input logic [LEN_CODED_BLOCK-1:0] d, input logic [23:0] e);
        return (d[65:64] == 2'b10) && (d[63:40] == e) && (d[31:8] == ~e);
    endfunction

    // Payload bit i lands in BIP bit 7-(i%8); the two sync-header bits fold into bits 3 and 4.
    function automatic logic [7:0] bip_of(input logic [LEN_CODED_BLOCK-1:0] d);
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = ^(d[63:0] & {8{8'h80 >> k}});
        b[3] = b[3] ^ d[65];
        b[4] = b[4] ^ d[64];
        return b;
    endfunction

    assign accept    = i_valid && i_enable;
    assign expected  = (timer_q == i_am_period - NB_PERIOD'(1));
    assign blk_bip   = bip_of(i_data);
    assign lane_hit  = am_match(i_data, lane_entry);
    assign inv_next  = {1'b0, inv_q} + INV_ONE;
    assign inv_limit = (i_max_invalid_am == '0) ? INV_ONE : {1'b0, i_max_invalid_am};

    // Scan downwards so the lowest matching index wins.
    always_comb begin
        any_hit = 1'b0;
        hit_idx = '0;
        for (int k = N_ALIGNER - 1; k >= 0; k--) begin
            if (am_match(i_data, AM_TABLE[24*k +: 24])) begin
                any_hit = 1'b1;
                hit_idx = NB_LANE_ID'(k);
            end
        end
    end

    always_comb begin
        lane_entry = '0;
        for (int k = 0; k < N_ALIGNER; k++) begin
            if (lane_q == NB_LANE_ID'(k)) lane_entry = AM_TABLE[24*k +: 24];
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        lane_d    = lane_q;
        inv_d     = inv_q;
        acc_d     = acc_q;
        data_d    = data_q;
        valid_d   = accept;
        lock_d    = lock_q;
        resync_d  = 1'b0;
        sol_d     = 1'b0;
        bip_err_d = 1'b0;
        cnt_d     = cnt_q;
        am_accept = 1'b0;
        bip_inc   = 1'b0;
        if (i_enable) begin
            if (!i_block_lock) begin
                state_d = LOCK_INIT;
                lock_d  = 1'b0;
                timer_d = '0;
                inv_d   = '0;
            end else begin
                case (state_q)
                    LOCK_INIT: begin
                        state_d = FIND_1ST;
                        timer_d = '0;
                    end
                    FIND_1ST: begin
                        if (accept && any_hit) begin
                            lane_d    = hit_idx;
                            timer_d   = '0;
                            am_accept = 1'b1;
                            state_d   = COUNT_1;
                        end
                    end
                    COUNT_1: begin
                        if (accept && !expected) begin
                            timer_d = timer_q + NB_PERIOD'(1);
                        end else if (accept) begin
                            timer_d = '0;
                            if (lane_hit) begin
                                lock_d    = 1'b1;
                                inv_d     = '0;
                                sol_d     = 1'b1;
                                am_accept = 1'b1;
                                state_d   = COUNT_NEXT;
                            end else begin
                                resync_d = 1'b1;
                                state_d  = FIND_1ST;
                            end
                        end
                    end
                    COUNT_NEXT: begin
                        if (accept && !expected) begin
                            timer_d = timer_q + NB_PERIOD'(1);
                        end else if (accept) begin
                            timer_d = '0;
                            if (lane_hit) begin
                                inv_d     = '0;
                                sol_d     = 1'b1;
                                am_accept = 1'b1;
                                bip_inc   = (acc_q != i_data[39:32]);
                                bip_err_d = bip_inc;
                            end else if (inv_next >= inv_limit) begin
                                lock_d   = 1'b0;
                                resync_d = 1'b1;
                                inv_d    = '0;
                                state_d  = LOCK_INIT;
                            end else begin
                                inv_d = inv_next[NB_INV_AM-1:0];
                            end
                        end
                    end
                    default: state_d = LOCK_INIT;
                endcase
            end
            // An accepted AM restarts the BIP window with its own contribution.
            if (accept) begin
                data_d = am_accept ? IDLE_BLOCK : i_data;
                acc_d  = am_accept ? blk_bip : (acc_q ^ blk_bip);
            end
            if ((state_d == FIND_1ST) && (state_q != FIND_1ST)) acc_d = '0;
            if (i_clear_counter) cnt_d = '0;
            else if (bip_inc && (cnt_q != '1)) cnt_d = cnt_q + NB_ERROR_COUNTER'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= LOCK_INIT;
            timer_q   <= '0;
            lane_q    <= '0;
            inv_q     <= '0;
            acc_q     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            lock_q    <= 1'b0;
            resync_q  <= 1'b0;
            sol_q     <= 1'b0;
            bip_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            lane_q    <= lane_d;
            inv_q     <= inv_d;
            acc_q     <= acc_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            lock_q    <= lock_d;
            resync_q  <= resync_d;
            sol_q     <= sol_d;
            bip_err_q <= bip_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_data            = data_q;
    assign o_valid           = valid_q;
    assign o_lane_id         = lane_q;
    assign o_am_lock         = lock_q;
    assign o_resync          = resync_q;
    assign o_start_of_lane   = sol_q;
    assign o_bip_error       = bip_err_q;
    assign o_bip_error_count = cnt_q;

endmodule

// File: tb/tb_am_lock_bip_module.sv
// Bench for am_lock_bip_module: a table of per-cycle rows (inputs plus expected outputs)
// built from an AM/BIP3 generator, applied through a scoreboard queue.
module tb_am_lock_bip_module;

    localparam int CW = 3;
    localparam logic [65:0] IDLE = {2'b10, 8'h1E, 56'h0};

    typedef struct packed {
        logic [65:0]   data;
        logic          valid;
        logic          lock;
        logic          resync;
        logic          sol;
        logic          be;
        logic [4:0]    lane;
        logic [CW-1:0] cnt;
    } exp_t;
    localparam int EW = $bits(exp_t);

    typedef struct {
        logic [65:0] d;
        logic        v;
        logic        en;
        logic        bl;
        logic        clr;
        exp_t        e;
        string       tag;
    } row_t;

    logic          clk;
    logic          i_reset, i_enable, i_valid, i_block_lock, i_clear_counter;
    logic [65:0]   i_data;
    logic [14:0]   i_am_period;
    logic [2:0]    i_max_invalid_am;
    logic [65:0]   o_data;
    logic          o_valid, o_am_lock, o_resync, o_start_of_lane, o_bip_error;
    logic [4:0]    o_lane_id;
    logic [CW-1:0] o_bip_error_count;

    am_lock_bip_module #(.NB_ERROR_COUNTER(CW)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_block_lock(i_block_lock), .i_data(i_data), .i_am_period(i_am_period),
        .i_max_invalid_am(i_max_invalid_am), .i_clear_counter(i_clear_counter),
        .o_data(o_data), .o_valid(o_valid), .o_lane_id(o_lane_id), .o_am_lock(o_am_lock),
        .o_resync(o_resync), .o_start_of_lane(o_start_of_lane), .o_bip_error(o_bip_error),
        .o_bip_error_count(o_bip_error_count)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    row_t          rows[$];
    logic [EW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    logic          cur_lock = 1'b0;
    logic [4:0]    cur_lane = '0;
    logic [CW-1:0] cur_cnt  = '0;
    logic [65:0]   last_data = '0;
    logic [7:0]    tx_acc = '0;

    function automatic logic [23:0] am_entry(input int lane);
        case (lane)
            0: return 24'hC16821;
            5: return 24'hDD14C2;
            default: return 24'h000000;
        endcase
    endfunction

    // Reference BIP3 in transmit order.
    function automatic logic [7:0] bip_ref(input logic [65:0] d);
        logic [7:0] b;
        logic       bv;
        b = '0;
        for (int t = 0; t < 66; t++) begin
            bv = d[65 - t];
            if (t >= 2) b[(t - 2) % 8] = b[(t - 2) % 8] ^ bv;
            else if (t == 0) b[3] = b[3] ^ bv;
            else b[4] = b[4] ^ bv;
        end
        return b;
    endfunction

    task automatic add_row(input logic [65:0] d, input logic v, input logic en, input logic bl,
                           input logic clr, input logic am_ok, input logic rs, input logic sol,
                           input logic be, input string tag);
        row_t r;
        if (v && en) last_data = am_ok ? IDLE : d;
        r.d = d; r.v = v; r.en = en; r.bl = bl; r.clr = clr; r.tag = tag;
        r.e.data = last_data; r.e.valid = v && en; r.e.lock = cur_lock; r.e.resync = rs;
        r.e.sol = sol; r.e.be = be; r.e.lane = cur_lane; r.e.cnt = cur_cnt;
        rows.push_back(r);
    endtask

    task automatic data_row(input string tag, input logic v = 1'b1, input logic en = 1'b1,
                            input logic bl = 1'b1, input logic clr = 1'b0,
                            input logic flip = 1'b0, input logic rs = 1'b0);
        logic [65:0] tx, rx;
        int          pos;
        tx = {2'b01, $urandom(), $urandom()};
        rx = tx;
        if (flip) begin
            pos = $urandom_range(63, 0);
            rx[pos] = ~rx[pos];
        end
        if (v && en) tx_acc = tx_acc ^ bip_ref(tx);
        add_row(rx, v, en, bl, clr, 1'b0, rs, 1'b0, 1'b0, tag);
    endtask

    task automatic data_run(input int n, input string tag, input logic flip_first = 1'b0);
        for (int i = 0; i < n; i++) data_row(tag, 1'b1, 1'b1, 1'b1, 1'b0, flip_first && (i == 0));
    endtask

    task automatic am_row(input int lane, input string tag, input logic ok = 1'b1,
                          input logic corrupt = 1'b0, input logic sol = 1'b0, input logic be = 1'b0,
                          input logic rs = 1'b0, input logic clr = 1'b0);
        logic [23:0] e;
        logic [65:0] d;
        e = am_entry(lane);
        d = {2'b10, e, tx_acc, ~e, 8'h5A};
        if (corrupt) d[63:56] = d[63:56] ^ 8'h10;
        if (ok) tx_acc = bip_ref(d);
        else tx_acc = tx_acc ^ bip_ref(d);
        add_row(d, 1'b1, 1'b1, 1'b1, clr, ok, rs, sol, be, tag);
    endtask

    task automatic check_val(input string name, input logic [65:0] got, input logic [65:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic check_out(input string tag, input int n);
        exp_t e, g;
        e = exp_q.pop_front();
        g = {o_data, o_valid, o_am_lock, o_resync, o_start_of_lane, o_bip_error, o_lane_id,
             o_bip_error_count};
        n_cmp++;
        if (g !== e) begin
            n_err++;
            $display("FAIL %s row %0d: got data=%h v=%b lock=%b rs=%b sol=%b be=%b lane=%0d cnt=%0d, required data=%h v=%b lock=%b rs=%b sol=%b be=%b lane=%0d cnt=%0d",
                     tag, n, g.data, g.valid, g.lock, g.resync, g.sol, g.be, g.lane, g.cnt,
                     e.data, e.valid, e.lock, e.resync, e.sol, e.be, e.lane, e.cnt);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check_val({pfx, "_data"}, o_data, '0);
        check_val({pfx, "_valid"}, 66'(o_valid), '0);
        check_val({pfx, "_lane"}, 66'(o_lane_id), '0);
        check_val({pfx, "_lock"}, 66'(o_am_lock), '0);
        check_val({pfx, "_resync"}, 66'(o_resync), '0);
        check_val({pfx, "_sol"}, 66'(o_start_of_lane), '0);
        check_val({pfx, "_bip_err"}, 66'(o_bip_error), '0);
        check_val({pfx, "_cnt"}, 66'(o_bip_error_count), '0);
    endtask

    initial begin
        // Build the vector table.
        data_row("p1_init");
        data_row("p1_find_miss");
        cur_lane = 5'd0; am_row(0, "p1_am1");
        data_run(7, "p1_dat");
        cur_lock = 1'b1; am_row(0, "p1_am2", 1'b1, 1'b0, 1'b1);
        for (int p = 0; p < 2; p++) begin
            data_run(7, "p1_dat");
            am_row(0, "p1_amn", 1'b1, 1'b0, 1'b1);
        end
        cur_lock = 1'b0; data_row("p2_bl_drop", 1'b1, 1'b1, 1'b0);
        data_row("p2_relock");
        cur_lane = 5'd5; am_row(5, "p3_am1");
        data_run(7, "p3_dat");
        data_row("p3_slip", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        data_run(3, "p3_find");
        am_row(5, "p3_am1b");
        data_run(7, "p3_dat");
        cur_lock = 1'b1; am_row(5, "p3_am2", 1'b1, 1'b0, 1'b1);
        data_row("p4_d"); data_row("p4_gap", 1'b0); data_row("p4_d"); data_row("p4_d");
        data_row("p4_en0", 1'b1, 1'b0); data_row("p4_d"); data_row("p4_gap", 1'b0);
        data_row("p4_d"); data_row("p4_d"); data_row("p4_d");
        am_row(5, "p4_am", 1'b1, 1'b0, 1'b1);
        for (int p = 0; p < 2; p++) begin
            data_run(7, "p5_dat");
            am_row(5, "p5_bad", 1'b0, 1'b1);
        end
        data_run(7, "p5_dat");
        am_row(5, "p5_good", 1'b1, 1'b0, 1'b1);
        for (int p = 0; p < 2; p++) begin
            data_run(7, "p5_dat");
            am_row(5, "p5_bad2", 1'b0, 1'b1);
        end
        data_run(7, "p5_dat");
        cur_lock = 1'b0; am_row(5, "p5_loss", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        data_row("p6_init");
        am_row(5, "p6_am1");
        data_run(7, "p6_dat");
        cur_lock = 1'b1; am_row(5, "p6_am2", 1'b1, 1'b0, 1'b1);
        for (int p = 0; p < 4; p++) begin
            data_run(7, "p6_flip", 1'b1);
            cur_cnt++;
            am_row(5, "p6_bip", 1'b1, 1'b0, 1'b1, 1'b1);
        end
        cur_cnt = '0; data_row("p6_clear", 1'b1, 1'b1, 1'b1, 1'b1);
        data_run(6, "p6_dat");
        am_row(5, "p6_clean", 1'b1, 1'b0, 1'b1);
        for (int p = 0; p < 8; p++) begin
            data_run(7, "p6_sat", 1'b1);
            if (cur_cnt != '1) cur_cnt++;
            am_row(5, "p6_sat_am", 1'b1, 1'b0, 1'b1, 1'b1);
        end
        data_run(7, "p6_flip", 1'b1);
        cur_cnt = '0; am_row(5, "p6_clr_pri", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        data_run(7, "p6_flip", 1'b1);
        cur_cnt = 1; am_row(5, "p6_last", 1'b1, 1'b0, 1'b1, 1'b1);
        data_run(3, "p6_tail");

        // Reset state.
        i_reset = 1'b1; i_enable = 1'b0; i_valid = 1'b0; i_block_lock = 1'b0;
        i_clear_counter = 1'b0; i_data = '0; i_am_period = 15'd8; i_max_invalid_am = 3'd3;
        #1 i_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        @(negedge clk) i_reset = 1'b1;

        // Apply the table.
        for (int n = 0; n < rows.size(); n++) begin
            @(negedge clk);
            i_data = rows[n].d; i_valid = rows[n].v; i_enable = rows[n].en;
            i_block_lock = rows[n].bl; i_clear_counter = rows[n].clr;
            exp_q.push_back(rows[n].e);
            @(posedge clk);
            #1 check_out(rows[n].tag, n);
        end

        // Asynchronous reset in the middle of a period while locked.
        check_val("pre_reset_lock", 66'(o_am_lock), 66'd1);
        check_val("pre_reset_cnt", 66'(o_bip_error_count), 66'd1);
        #2 i_reset = 1'b0;
        #1 check_all_zero("async_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
